// File: rtl/tlb_probe_read_if.sv
// tlb_probe_read_if: CPU, CP0 and TLB read-port signals of the TLBP/TLBR reader; master drives instruction/CP0/TLB data, slave is the reader.
interface tlb_probe_read_if #(parameter int IDX_W = 4);
  logic inst_valid_i;
  logic [31:0] inst_i;
  logic flush_i;
  logic [31:0] index_i;
  logic [31:0] entryhi_i;
  logic [IDX_W-1:0] tlb_rd_idx_o;
  logic [95:0] tlb_rd_data_i;
  logic stall_o;
  logic done_o;
  logic index_we_o;
  logic [31:0] index_data_o;
  logic entryhi_we_o;
  logic [31:0] entryhi_data_o;
  logic entrylo0_we_o;
  logic [31:0] entrylo0_data_o;
  logic entrylo1_we_o;
  logic [31:0] entrylo1_data_o;
  modport master (
    output inst_valid_i, inst_i, flush_i, index_i, entryhi_i, tlb_rd_data_i,
    input tlb_rd_idx_o, stall_o, done_o, index_we_o, index_data_o, entryhi_we_o, entryhi_data_o,
          entrylo0_we_o, entrylo0_data_o, entrylo1_we_o, entrylo1_data_o
  );
  modport slave (
    input inst_valid_i, inst_i, flush_i, index_i, entryhi_i, tlb_rd_data_i,
    output tlb_rd_idx_o, stall_o, done_o, index_we_o, index_data_o, entryhi_we_o, entryhi_data_o,
           entrylo0_we_o, entrylo0_data_o, entrylo1_we_o, entrylo1_data_o
  );
endinterface

// File: rtl/tlb_probe_read.sv
// tlb_probe_read: multi-cycle TLBP/TLBR engine; clk/rst plus bus (instruction in, TLB read port, stall, done and CP0 Index/EntryHi/EntryLo0/EntryLo1 write pulses).
module tlb_probe_read #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W = 4
) (
  input logic clk,
  input logic rst,
  tlb_probe_read_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PROBE, READ, DONE} state_t;
  state_t state;
  logic [IDX_W-1:0] cnt, hit_idx;
  logic [18:0] tgt_vpn2;
  logic [7:0] tgt_asid;
  logic hit, is_probe;
  logic [95:0] rd_buf;
  logic is_tlbp, is_tlbr, accept, match, last, wr, unused_bits;
  assign is_tlbp = bus.inst_i == 32'h42000008;
  assign is_tlbr = bus.inst_i == 32'h42000001;
  assign accept = state == IDLE && bus.inst_valid_i && !bus.flush_i && (is_tlbp || is_tlbr);
  assign match = bus.tlb_rd_data_i[95:77] == tgt_vpn2 && bus.tlb_rd_data_i[71:64] == tgt_asid;
  assign last = cnt == IDX_W'(TLB_ENTRIES - 1);
  assign wr = state == DONE && !bus.flush_i && !rst;
  assign unused_bits = ^{bus.index_i[31:IDX_W], bus.entryhi_i[12:8], bus.tlb_rd_data_i[76:72]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hit_idx <= '0;
      tgt_vpn2 <= '0;
      tgt_asid <= '0;
      hit <= 1'b0;
      is_probe <= 1'b0;
      rd_buf <= '0;
    end else if (bus.flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (accept) begin
          is_probe <= is_tlbp;
          if (is_tlbp) begin
            tgt_vpn2 <= bus.entryhi_i[31:13];
            tgt_asid <= bus.entryhi_i[7:0];
            cnt <= '0;
            hit <= 1'b0;
            state <= PROBE;
          end else begin
            hit_idx <= bus.index_i[IDX_W-1:0];
            state <= READ;
          end
        end
        PROBE: if (match) begin
          hit <= 1'b1;
          hit_idx <= cnt;
          state <= DONE;
        end else if (last) begin
          hit <= 1'b0;
          state <= DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        READ: begin
          rd_buf <= bus.tlb_rd_data_i;
          state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
  assign bus.tlb_rd_idx_o = rst ? '0 : state == PROBE ? cnt : state == READ ? hit_idx : '0;
  assign bus.stall_o = !rst && (accept || state == PROBE || state == READ);
  assign bus.done_o = wr;
  assign bus.index_we_o = wr && is_probe;
  assign bus.entryhi_we_o = wr && !is_probe;
  assign bus.entrylo0_we_o = wr && !is_probe;
  assign bus.entrylo1_we_o = wr && !is_probe;
  assign bus.index_data_o = !is_probe ? '0 : hit ? {{(32-IDX_W){1'b0}}, hit_idx} : 32'h80000000;
  assign bus.entryhi_data_o = rd_buf[95:64];
  assign bus.entrylo0_data_o = rd_buf[63:32];
  assign bus.entrylo1_data_o = rd_buf[31:0];
endmodule

// File: tb/tb_tlb_probe_read.sv
// tb_tlb_probe_read: directed and randomized checks of tlb_probe_read against a TLB lookup model.
module tb_tlb_probe_read;
  localparam logic [31:0] TLBP = 32'h42000008;
  localparam logic [31:0] TLBR = 32'h42000001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [95:0] tlb [16];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  tlb_probe_read_if #(.IDX_W(4)) b();
  tlb_probe_read #(.TLB_ENTRIES(16), .IDX_W(4)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  assign b.tlb_rd_data_i = tlb[b.tlb_rd_idx_o];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] outs();
    return {26'b0, b.stall_o, b.done_o, b.index_we_o, b.entryhi_we_o, b.entrylo0_we_o, b.entrylo1_we_o};
  endfunction
  function automatic int probe_model(input logic [18:0] vpn2, input logic [7:0] asid);
    for (int i = 0; i < 16; i++)
      if (tlb[i][95:77] == vpn2 && tlb[i][71:64] == asid) return i;
    return -1;
  endfunction
  task automatic clear_tlb();
    for (int i = 0; i < 16; i++) tlb[i] = {19'h40000 + 19'(i), 5'b0, 8'hFF, 32'(i), 32'(i * 3)};
  endtask
  task automatic run_op(input logic [31:0] ins, input logic [31:0] idx, input logic [31:0] ehi, input string tag);
    int k, exp_cyc, cyc;
    logic [31:0] exp_idx;
    logic is_p;
    is_p = ins == TLBP;
    k = probe_model(ehi[31:13], ehi[7:0]);
    exp_cyc = !is_p ? 2 : k < 0 ? 17 : k + 2;
    exp_idx = k < 0 ? 32'h80000000 : 32'(k);
    @(negedge clk);
    b.inst_valid_i = 1'b1;
    b.inst_i = ins;
    b.index_i = idx;
    b.entryhi_i = ehi;
    #1;
    chk({tag, " accept"}, outs(), 32'h20);
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
      if (!b.done_o) chk({tag, " busy"}, outs(), 32'h20);
    end while (!b.done_o && cyc < 40);
    chk({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, " done_outs"}, outs(), is_p ? 32'h18 : 32'h17);
    if (is_p) chk({tag, " index_data"}, b.index_data_o, exp_idx);
    else begin
      chk({tag, " entryhi_data"}, b.entryhi_data_o, tlb[idx[3:0]][95:64]);
      chk({tag, " entrylo0_data"}, b.entrylo0_data_o, tlb[idx[3:0]][63:32]);
      chk({tag, " entrylo1_data"}, b.entrylo1_data_o, tlb[idx[3:0]][31:0]);
    end
  endtask
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        b.inst_valid_i = 1'b0;
        b.flush_i = 1'b0;
        rst = 1'b0;
      end
      #1;
      chk({tag, " idle_outs"}, outs(), 32'h0);
      chk({tag, " idle_rd_idx"}, 32'(b.tlb_rd_idx_o), 32'h0);
    end
  endtask
  initial begin
    b.inst_valid_i = 1'b0;
    b.inst_i = '0;
    b.flush_i = 1'b0;
    b.index_i = '0;
    b.entryhi_i = '0;
    clear_tlb();
    repeat (2) @(negedge clk);
    #1;
    chk("reset outs", outs(), 32'h0);
    chk("reset rd_idx", 32'(b.tlb_rd_idx_o), 32'h0);
    chk("reset index_data", b.index_data_o, 32'h0);
    chk("reset entryhi_data", b.entryhi_data_o, 32'h0);
    chk("reset entrylo0_data", b.entrylo0_data_o, 32'h0);
    chk("reset entrylo1_data", b.entrylo1_data_o, 32'h0);
    idle(2, "post_reset");
    tlb[5] = {19'h00001, 5'b0, 8'h2A, 64'h0};
    run_op(TLBP, 32'h0, 32'h0000202A, "probe_hit5");
    chk("probe_hit5 literal", b.index_data_o, 32'h00000005);
    idle(2, "after_hit5");
    clear_tlb();
    tlb[3] = {19'h00001, 5'h1F, 8'h2A, 64'h1};
    tlb[9] = {19'h00001, 5'h00, 8'h2A, 64'h2};
    run_op(TLBP, 32'h0, 32'h0000202A, "probe_dup");
    chk("probe_dup literal", b.index_data_o, 32'h00000003);
    idle(1, "after_dup");
    run_op(TLBP, 32'h0, 32'h0000202B, "probe_miss");
    chk("probe_miss literal", b.index_data_o, 32'h80000000);
    idle(1, "after_miss");
    tlb[12] = {32'h12340055, 32'h00ABC006, 32'h00ABD007};
    run_op(TLBR, 32'h0000000C, 32'h0, "read12");
    chk("read12 entryhi literal", b.entryhi_data_o, 32'h12340055);
    chk("read12 index_we", 32'(b.index_we_o), 32'h0);
    idle(2, "after_read12");
    run_op(TLBR, 32'h0000000C, 32'h0, "b2b_read");
    run_op(TLBP, 32'h0, 32'h0000202A, "b2b_probe");
    idle(2, "after_b2b");
    tlb[10] = {19'h00077, 5'b0, 8'h11, 64'h5};
    @(negedge clk);
    b.inst_valid_i = 1'b1;
    b.inst_i = TLBP;
    b.entryhi_i = {19'h00077, 5'b0, 8'h11};
    repeat (4) @(negedge clk);
    b.flush_i = 1'b1;
    #1;
    chk("flush_probe outs", outs() & 32'h1F, 32'h0);
    idle(20, "flush_probe");
    @(negedge clk);
    b.inst_valid_i = 1'b1;
    b.inst_i = TLBR;
    b.index_i = 32'h3;
    repeat (2) @(negedge clk);
    b.flush_i = 1'b1;
    #1;
    chk("flush_done outs", outs() & 32'h1F, 32'h0);
    idle(3, "flush_done");
    @(negedge clk);
    b.inst_valid_i = 1'b1;
    b.inst_i = TLBP;
    b.entryhi_i = 32'hFFFFE0FF;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_probe outs0", outs(), 32'h0);
    @(negedge clk);
    #1;
    chk("rst_probe outs1", outs(), 32'h0);
    chk("rst_probe rd_idx", 32'(b.tlb_rd_idx_o), 32'h0);
    chk("rst_probe index_data", b.index_data_o, 32'h0);
    chk("rst_probe entryhi_data", b.entryhi_data_o, 32'h0);
    idle(20, "rst_probe");
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 16; i++)
        tlb[i] = {19'($urandom_range(0, 3)), 5'($urandom), 8'($urandom_range(0, 3)), 32'($urandom), 32'($urandom)};
      case ($urandom_range(0, 2))
        0: run_op(TLBP, $urandom, {19'($urandom_range(0, 5)), 5'($urandom), 8'($urandom_range(0, 3))}, "rand_probe");
        1: run_op(TLBR, $urandom, $urandom, "rand_read");
        default: begin
          @(negedge clk);
          b.inst_valid_i = 1'b1;
          b.inst_i = $urandom & 32'hFFFFFFF0;
          #1;
          chk("rand_other outs", outs(), 32'h0);
        end
      endcase
      idle($urandom_range(1, 2), "rand_idle");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tlb_probe_read.md
# tlb_probe_read

Multi-cycle TLB reader that executes TLBP (probe) and TLBR (read) for the CPU, the read-side counterpart of the TLBWI/TLBWR write path. It sits beside the TLB entry array in the MEM stage. It scans or indexes entries through a single read port, stalls the pipeline while busy, and returns results as one-cycle CP0 write pulses for Index, EntryHi, EntryLo0 and EntryLo1.

## Interface
- TLB_ENTRIES, 16, number of TLB entries scanned by TLBP.
- IDX_W, 4, entry index width (log2 TLB_ENTRIES).
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- inst_valid_i  in  1  a valid instruction is present on inst_i.
- inst_i  in  32  instruction word; TLBP = 32'h42000008, TLBR = 32'h42000001, others ignored.
- flush_i  in  1  exception/flush; aborts any operation.
- index_i  in  32  current (forwarded) CP0 Index.
- entryhi_i  in  32  current (forwarded) CP0 EntryHi.
- tlb_rd_idx_o  out  IDX_W  TLB read-port address.
- tlb_rd_data_i  in  96  entry at tlb_rd_idx_o, valid the same cycle: [95:64] EntryHi, [63:32] EntryLo0, [31:0] EntryLo1; VPN2 = [95:77], ASID = [71:64].
- stall_o  out  1  hold the pipeline.
- done_o  out  1  one-cycle completion pulse.
- index_we_o / index_data_o  out  1/32  CP0 Index write.
- entryhi_we_o / entryhi_data_o  out  1/32  CP0 EntryHi write.
- entrylo0_we_o / entrylo0_data_o  out  1/32  CP0 EntryLo0 write.
- entrylo1_we_o / entrylo1_data_o  out  1/32  CP0 EntryLo1 write.

## Operation
- States: IDLE, PROBE, READ, DONE. Registers: cnt (IDX_W), tgt_vpn2 (19), tgt_asid (8), hit (1), hit_idx (IDX_W), rd_buf (96).
- IDLE, inst_valid_i and TLBP, !flush_i: capture entryhi_i[31:13] and [7:0], cnt=0, hit=0 -> PROBE.
- IDLE, inst_valid_i and TLBR, !flush_i: hit_idx=index_i[IDX_W-1:0] -> READ.
- Any other word in IDLE: no action.
- PROBE: tlb_rd_idx_o=cnt. Match when tlb_rd_data_i[95:77]==tgt_vpn2 and [71:64]==tgt_asid; G bit is ignored.
  - On match: hit=1, hit_idx=cnt -> DONE.
  - No match and cnt==TLB_ENTRIES-1: hit=0 -> DONE.
  - Otherwise cnt+1.
  - Lowest matching index wins.
- READ: tlb_rd_idx_o=hit_idx; rd_buf=tlb_rd_data_i -> DONE.
- DONE (one cycle, always -> IDLE): done_o=1.
  - TLBP: index_we_o=1; index_data_o={28'b0,hit_idx} on hit, 32'h80000000 (P bit) on miss.
  - TLBR: entryhi_we_o, entrylo0_we_o, entrylo1_we_o=1, data = rd_buf slices.
  - inst_i is ignored in DONE, so the same instruction is never re-accepted.
- flush_i in any state: next state IDLE. All we_o and done_o are gated low combinationally in that cycle, including in DONE.
- tlb_rd_idx_o is 0 in IDLE and DONE.

## Timing
- Reset: state IDLE. All registers 0. stall_o, done_o, all *_we_o and *_data_o, and tlb_rd_idx_o are 0.
- stall_o = (IDLE and a recognized TLBP/TLBR is valid and !flush_i) or PROBE or READ. It is low in DONE, so the pipeline advances on the DONE edge.
- Cycle 0 is the acceptance cycle (IDLE).
- TLBP hit at entry k: PROBE cycles 1..k+1, DONE at cycle k+2; stall_o high cycles 0..k+1.
- TLBP miss: PROBE cycles 1..16, DONE at cycle 17; stall_o high cycles 0..16.
- TLBR: READ at cycle 1, DONE at cycle 2; stall_o high cycles 0..1.
- Write data outputs come from registers and are stable throughout DONE; all *_we_o last exactly one cycle.
- rst mid-operation: IDLE next cycle, no writes, no done_o.
- Back-to-back instructions: a new TLBP/TLBR is accepted in the IDLE cycle immediately after DONE.

## Test plan
- Reset: assert rst 2 cycles during a PROBE -> all outputs 0, state IDLE, no we pulse afterwards.
- TLBP hit: entry 5 = VPN2 19'h00001, ASID 8'h2A; entryhi_i=32'h0000202A -> stall_o high 7 cycles; DONE at cycle 7 with index_we_o=1, index_data_o=32'h00000005.
- TLBP duplicate and miss:
  - Entries 3 and 9 both match -> index_data_o=3 at cycle 5.
  - Same VPN2 with ASID 8'h2B -> index_data_o=32'h80000000 at cycle 17.
- TLBR: index_i=32'h0000000C, entry 12 = {32'h12340055, 32'h00ABC006, 32'h00ABD007} -> DONE at cycle 2; EntryHi/Lo0/Lo1 written with exactly those values, index_we_o=0.
- Flush: flush_i at PROBE cycle 4, and separately in the DONE cycle of a TLBR -> no we_o and no done_o; IDLE next cycle.
- Back-to-back: TLBR then TLBP on consecutive instructions -> second accepted the cycle after the first DONE; each produces exactly one done_o.
